approx_mul_ha_pipe: RTL
=======================

Name: approx_mul_ha_pipe

Overview:
Parametrised, pipelined unsigned WIDTHxWIDTH multiplier built on a half-adder pairing array, with a run-time exact/approximate mode.
- Rows of partial products are paired through half adders.
- In approximate mode, low columns are eliminated and the next columns use OR-sum with the carry dropped.
- The block carries a valid/ready handshake and reports the approximation error (exact minus approximate) for on-line error monitoring.
- It sits between operand FIFOs and downstream accumulation logic in the approximate-arithmetic datapath.

Parameters:
WIDTH, 8, operand width; even, 4..16
ELIM_COLS, 4, absolute columns below this value: HA pair positions forced to 0 (sum and carry)
OR_COLS, 2, absolute columns [ELIM_COLS, ELIM_COLS+OR_COLS): sum=a|b, carry=0

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand transfer request
in_ready  out  1  block can accept operands
x  in  WIDTH  multiplicand, unsigned
y  in  WIDTH  multiplier, unsigned
mode  in  1  0 = exact, 1 = approximate; sampled with x/y
out_valid  out  1  product available
out_ready  in  1  downstream accepts product
p  out  2*WIDTH  product (exact or approximate per captured mode)
err  out  2*WIDTH  exact product minus p; always >= 0
out_mode  out  1  mode the product was computed with

Behaviour:
- Partial product: pp[i][j] = x[i] & y[j], weight 2^(i+j).
- HA array: pairs k = 0..WIDTH/2-1 combine rows 2k and 2k+1.
- Pass-through positions: pp[2k][0] at weight 2^(2k) and pp[2k+1][WIDTH-1] at weight 2^(2k+WIDTH) pass through unmodified in both modes.
- HA positions: for c = 1..WIDTH-1, a = pp[2k][c] and b = pp[2k+1][c-1]; absolute column n = 2k+c.
- Exact, or approximate with n >= ELIM_COLS+OR_COLS: sum = a^b at 2^n, carry = a&b at 2^(n+1).
- Approximate with n < ELIM_COLS: sum = carry = 0.
- Approximate with ELIM_COLS <= n < ELIM_COLS+OR_COLS: sum = a|b, carry = 0.
- Pipeline, 3 stages:
  - S0: capture x, y, mode.
  - S1: register HA array outputs (sum/carry/pass-through vectors per pair) plus the exact product of the S0 operands.
  - S2: register the final sum of all pair vectors (p), err = exact - p, and mode.
- Latency: 3 cycles from in_valid&&in_ready to out_valid with no back-pressure.
- Handshake:
  - Stall-all pipeline; advance = !out_valid || out_ready; in_ready = advance.
  - Each stage has a valid bit; a bubble advances like data.
  - Throughput is 1 result/cycle while out_ready = 1.
  - When out_valid=1 and out_ready=0, p, err, out_mode and out_valid hold stable and no stage moves.
  - in_valid while in_ready=0: operands are not captured; the source must hold them.
- Mode is per-transaction and travels with its data; changing mode between back-to-back operands is legal with no bubble.
- Widths: final sum and err are 2*WIDTH bits, computed without overflow; err = 0 whenever out_mode = 0.
- Reset (asynchronous, any time, including mid-operation): all stage valids, out_valid, p, err and out_mode go to 0; in-flight operands are discarded. in_ready is 1 from the first cycle after rst_n deasserts.
- ELIM_COLS = 0 and OR_COLS = 0 gives an exact multiplier in both modes.
- Columns above 2*WIDTH-2 are never approximated by construction.

Test Plan:
1. WIDTH=8, mode=0, x=255, y=255 -> p=65025, err=0, out_valid exactly 3 cycles after the accept.
2. mode=1, x=255, y=255, ELIM_COLS=4, OR_COLS=2 -> p=64853, err=172. With OR_COLS=0 -> p=64981, err=44.
3. mode=1, x=3, y=1 -> p=1, err=2; mode=0 on the same operands in the next cycle -> p=3, err=0, out_mode=0, no bubble between results.
4. Stream 8 random operands with out_ready toggling 1/0 each cycle:
   - results arrive in order, none lost or duplicated;
   - outputs stay stable while out_ready=0;
   - in_ready=0 exactly when out_valid=1 and out_ready=0.
5. Assert rst_n low with 3 transactions in flight -> out_valid, p and err are 0 immediately (asynchronous); after release the first new operand produces a result at latency 3 and no stale data appears.
6. Sweep 2000 random x, y with mode=1 -> p + err equals x*y for every result; err <= 172 at the default parameters.

Source files
------------

// File: rtl/approx_mul_ha_pipe.sv
// approx_mul_ha_pipe: 3-stage unsigned WIDTHxWIDTH multiplier on a half-adder pairing array,
// with per-transaction exact/approximate mode and an exact-minus-approximate error output.
module approx_mul_ha_pipe #(
    parameter int WIDTH     = 8,
    parameter int ELIM_COLS = 4,
    parameter int OR_COLS   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic [2*WIDTH-1:0]   err,
    output logic                 out_mode
);
    localparam int PW = 2*WIDTH;
    localparam int NP = WIDTH/2;

    logic             w_adv;
    logic             r_v0, r_m0, r_v1, r_m1, r_v2, r_m2;
    logic [WIDTH-1:0] r_x0, r_y0;
    logic [PW-1:0]    r_exact, r_p, r_err, w_total;
    logic [WIDTH-1:0] w_a   [NP];
    logic [WIDTH-1:0] w_b   [NP];
    logic [PW-1:0]    w_sum [NP];
    logic [PW-1:0]    w_cry [NP];
    logic [PW-1:0]    r_sum [NP];
    logic [PW-1:0]    r_cry [NP];

    assign w_adv     = !r_v2 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v2;
    assign p         = r_p;
    assign err       = r_err;
    assign out_mode  = r_m2;

    // w_a[k][c] = pp[2k][c], w_b[k][c] = pp[2k+1][c-1] (the HA partner one column left)
    for (genvar g = 0; g < NP; g++) begin : g_rows
        assign w_a[g] = {WIDTH{r_x0[2*g]}} & r_y0;
        assign w_b[g] = {WIDTH{r_x0[2*g+1]}} & {r_y0[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        for (int k = 0; k < NP; k++) begin
            w_sum[k] = '0;
            w_cry[k] = '0;
            w_sum[k][2*k]       = w_a[k][0];
            w_sum[k][2*k+WIDTH] = r_x0[2*k+1] & r_y0[WIDTH-1];
            for (int c = 1; c < WIDTH; c++) begin
                if (!r_m0 || 2*k+c >= ELIM_COLS+OR_COLS) begin
                    w_sum[k][2*k+c]   = w_a[k][c] ^ w_b[k][c];
                    w_cry[k][2*k+c+1] = w_a[k][c] & w_b[k][c];
                end else if (2*k+c >= ELIM_COLS) begin
                    w_sum[k][2*k+c]   = w_a[k][c] | w_b[k][c];
                end
            end
        end
    end

    always_comb begin
        w_total = '0;
        for (int k = 0; k < NP; k++) w_total = w_total + r_sum[k] + r_cry[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0    <= 1'b0;
            r_m0    <= 1'b0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_v1    <= 1'b0;
            r_m1    <= 1'b0;
            r_sum   <= '{default: '0};
            r_cry   <= '{default: '0};
            r_exact <= '0;
            r_v2    <= 1'b0;
            r_m2    <= 1'b0;
            r_p     <= '0;
            r_err   <= '0;
        end else if (w_adv) begin
            r_v0    <= in_valid;
            r_m0    <= mode;
            r_x0    <= x;
            r_y0    <= y;
            r_v1    <= r_v0;
            r_m1    <= r_m0;
            r_sum   <= w_sum;
            r_cry   <= w_cry;
            r_exact <= PW'(r_x0) * PW'(r_y0);
            r_v2    <= r_v1;
            r_m2    <= r_m1;
            r_p     <= w_total;
            r_err   <= r_exact - w_total;
        end
    end
endmodule
